delay_probe: RTL
================

DELAY_PROBE -- requirements
Module: delay_probe

Interface
REQ-001 Parameter CW, default 16, SHALL set the counter and result width in bits.
REQ-002 Parameter TIMEOUT, default {CW{1'b1}}, SHALL set the maximum count before a measurement aborts; it SHALL be at least 1.
REQ-003 Parameter SYNC, default 2, SHALL set the number of synchronizer flops on echo; it SHALL be at least 2.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state is updated on the rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the reset; it is asynchronous and active-low (rst=0 resets).
REQ-006 Port start, input, 1 bit, SHALL request one measurement; it is sampled only in IDLE.
REQ-007 Port launch, output, 1 bit, SHALL drive input i of the downstream delay line, which is instantiated with Rval=0, Rpol=0 and shares rst.
REQ-008 Port echo, input, 1 bit, SHALL receive output o of that delay line; it is asynchronous to clk.
REQ-009 Port busy, output, 1 bit, SHALL be high whenever state is not IDLE.
REQ-010 Port done, output, 1 bit, SHALL be a one-cycle completion pulse.
REQ-011 Port result, output, CW bits, SHALL hold the last measured cycle count.
REQ-012 Port timeout, output, 1 bit, SHALL flag that the last measurement aborted.

Function
REQ-013 echo SHALL pass through a SYNC-flop synchronizer; echo_s is the last stage, and only echo_s SHALL be used by logic.
REQ-014 launch SHALL be a register; each measurement SHALL toggle it exactly once, so the line sees one edge per measurement.
REQ-015 States SHALL be IDLE, SETTLE, WAIT, DONE, encoded in registers.
REQ-016 IDLE, start=1, echo_s==launch: next edge toggles launch, clears count to 0, enters WAIT.
REQ-017 IDLE, start=1, echo_s!=launch: next edge clears count to 0, enters SETTLE; launch unchanged.
REQ-018 SETTLE: if echo_s==launch, next edge toggles launch, clears count, enters WAIT; else if count==TIMEOUT, next edge sets result=TIMEOUT, timeout=1, enters DONE; else count increments.
REQ-019 WAIT: if echo_s==launch, next edge sets result=count, timeout=0, enters DONE; else if count==TIMEOUT, next edge sets result=TIMEOUT, timeout=1, enters DONE; else count increments.
REQ-020 DONE SHALL last exactly one cycle with done=1, then return to IDLE; done SHALL be registered and high only in DONE.
REQ-021 count SHALL never exceed TIMEOUT and never wrap.
REQ-022 For an echo that is launch delayed by D whole clk cycles, result SHALL equal D+SYNC.
REQ-023 start while busy=1 SHALL be ignored and not queued; start held high SHALL begin a new measurement on the first IDLE cycle after DONE.
REQ-024 result and timeout SHALL hold their values until the next DONE.
REQ-025 Echo transitions occurring in IDLE or DONE SHALL NOT alter result, timeout, or count.

Reset
REQ-026 With rst=0: launch=0, all synchronizer flops=0, state=IDLE, count=0, result=0, timeout=0, done=0, busy=0, asynchronously.
REQ-027 Reset asserted mid-measurement SHALL abort it with no done pulse; after release the block SHALL be in IDLE with launch=0, matching the reset value of the delay line.
REQ-028 First start after reset release SHALL be accepted on the first clk edge where rst=1.

Verification
REQ-029 SYNC=2, echo = launch delayed 0 cycles, start pulse -> busy rises, done pulses once, result=2, timeout=0.
REQ-030 SYNC=2, echo = launch delayed 5 cycles, two back-to-back measurements -> result=7 both times; launch toggles 0->1, then 1->0.
REQ-031 TIMEOUT=10, echo tied 0 after launch=1 -> done pulses, result=10, timeout=1; a following measurement with a working echo clears timeout to 0.
REQ-032 echo held opposite to launch at start, released after 4 cycles -> block passes through SETTLE and launch toggles only after echo_s matches; result then equals D+SYNC.
REQ-033 start pulsed repeatedly during WAIT -> exactly one done per accepted start; result is unaffected.
REQ-034 rst driven 0 during WAIT, count=3 -> immediate launch=0, busy=0, done=0, result=0; no done pulse follows rst release.

Source files
------------

// File: rtl/delay_probe.sv
// -----------------------------------------------------------------------------
// delay_probe
//
// Measures the round-trip delay of an external delay line in clk cycles.
// Each measurement toggles `launch` exactly once and counts cycles until the
// synchronized `echo` comes back to the same level. If the line and the probe
// disagree when a measurement is requested (echo_s != launch), the probe waits
// in SETTLE for them to agree before launching. Both waits are bounded by
// TIMEOUT; an expired wait reports result=TIMEOUT with the timeout flag set.
//
// Parameters:
//   CW      - counter / result width in bits
//   TIMEOUT - largest count before a measurement aborts (>= 1)
//   SYNC    - number of synchronizer flops on echo (>= 2)
//
// Ports:
//   clk     - single clock, rising edge
//   rst     - asynchronous reset, active low
//   start   - measurement request, sampled only in IDLE
//   launch  - registered drive into the delay line input
//   echo    - delay line output, asynchronous to clk
//   busy    - high whenever the probe is not IDLE
//   done    - registered one-cycle completion pulse
//   result  - last measured cycle count (held until the next done)
//   timeout - last measurement aborted (held until the next done)
// -----------------------------------------------------------------------------
module delay_probe #(
    parameter int unsigned     CW      = 16,
    parameter logic [CW-1:0]   TIMEOUT = {CW{1'b1}},
    parameter int unsigned     SYNC    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          launch,
    input  logic          echo,
    output logic          busy,
    output logic          done,
    output logic [CW-1:0] result,
    output logic          timeout
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    state_e          state_q,   state_d;
    logic [SYNC-1:0] sync_q,    sync_d;
    logic            launch_q,  launch_d;
    logic [CW-1:0]   count_q,   count_d;
    logic [CW-1:0]   result_q,  result_d;
    logic            timeout_q, timeout_d;
    logic            done_q,    done_d;

    // Only the last synchronizer stage may be looked at by the FSM.
    logic echo_s;
    assign echo_s = sync_q[SYNC-1];

    // Line and probe agree: the last launch edge has propagated back.
    logic line_match;
    assign line_match = (echo_s == launch_q);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: every flop here is assigned with <= so all registers sample the
    // pre-edge values computed by the combinational block, regardless of
    // statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            sync_q    <= '0;
            launch_q  <= 1'b0;
            count_q   <= '0;
            result_q  <= '0;
            timeout_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sync_q    <= sync_d;
            launch_q  <= launch_d;
            count_q   <= count_d;
            result_q  <= result_d;
            timeout_q <= timeout_d;
            done_q    <= done_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and datapath
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written below gets a hold/default value first, so
        // no path through the case statement leaves one unassigned (no latch).
        state_d   = state_q;
        sync_d    = {sync_q[SYNC-2:0], echo};
        launch_d  = launch_q;
        count_d   = count_q;
        result_d  = result_q;
        timeout_d = timeout_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d = '0;
                    if (line_match) begin
                        launch_d = ~launch_q;
                        state_d  = ST_WAIT;
                    end else begin
                        state_d  = ST_SETTLE;
                    end
                end
            end

            // The line still carries an edge we did not launch in this
            // measurement; wait for it to settle before toggling launch.
            ST_SETTLE: begin
                if (line_match) begin
                    launch_d = ~launch_q;
                    count_d  = '0;
                    state_d  = ST_WAIT;
                end else if (count_q == TIMEOUT) begin
                    result_d  = TIMEOUT;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end

            // count is the number of edges since launch toggled, so the
            // synchronizer latency is included in the reported delay.
            ST_WAIT: begin
                if (line_match) begin
                    result_d  = count_q;
                    timeout_d = 1'b0;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else if (count_q == TIMEOUT) begin
                    result_d  = TIMEOUT;
                    timeout_d = 1'b1;
                    done_d    = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    always_comb begin
        busy = (state_q != ST_IDLE);
    end

    assign launch  = launch_q;
    assign done    = done_q;
    assign result  = result_q;
    assign timeout = timeout_q;

endmodule
